// File: rtl/core_pkg.sv
// Shared definitions for the RISC FSM core: widths, opcodes and fetch states.
package core_pkg;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned INSTR_W = 16;

    localparam logic [2:0] OPC_ADD  = 3'b000;
    localparam logic [2:0] OPC_SUB  = 3'b001;
    localparam logic [2:0] OPC_AND  = 3'b010;
    localparam logic [2:0] OPC_OR   = 3'b011;
    localparam logic [2:0] OPC_NOT  = 3'b100;
    localparam logic [2:0] OPC_LDI  = 3'b101;
    localparam logic [2:0] OPC_HALT = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory bus plus fetch-to-decode valid/ready channel.
interface instr_fetch_unit_if #(
    parameter int unsigned ADDR_W  = core_pkg::ADDR_W,
    parameter int unsigned INSTR_W = core_pkg::INSTR_W
);
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_instr;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;

    // Fetch unit side
    modport master (
        output imem_addr,
        input  imem_instr,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc
    );

    // Memory / decoder side
    modport slave (
        input  imem_addr,
        output imem_instr,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc
    );
endinterface

// File: rtl/instr_fetch_unit_out_reg.sv
// Fetch output register: holds one instruction with valid/ready and flush.
module fetch_out_reg #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               load,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [ADDR_W-1:0]  load_pc,
    input  logic               ready,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc
);
    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;

    // Next-state: flush drops the entry, load replaces it, a transfer empties it
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            instr_d = load_instr;
            pc_d    = load_pc;
        end else if (ready) begin
            valid_d = 1'b0;
        end
    end

    // Register storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid = valid_q;
    assign instr = instr_q;
    assign pc    = pc_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives instruction memory, hands instructions to decode.
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W   = core_pkg::ADDR_W,
    parameter int unsigned       INSTR_W  = core_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [2:0]        HALT_OPC = core_pkg::OPC_HALT
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_unit_if.master  bus,
    input  logic                run,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_target,
    output logic                halted,
    output logic                pc_wrapped,
    output logic [15:0]         fetch_count
);
    import core_pkg::*;

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               pc_wrapped_q, pc_wrapped_d;
    logic [15:0]        fetch_count_q, fetch_count_d;

    logic               flush;
    logic               capture;
    logic               transfer;
    logic               out_valid;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;

    // Handshake qualifiers; a redirect outside IDLE overrides capture and transfer
    always_comb begin
        flush    = redirect_valid && (state_q != IDLE);
        capture  = (state_q == FETCH) && !flush && (!out_valid || bus.out_ready);
        transfer = out_valid && bus.out_ready && !flush;
    end

    // Next-state logic for FSM, PC, wrap flag and delivered-instruction counter
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pc_wrapped_d  = pc_wrapped_q;
        fetch_count_d = fetch_count_q;

        case (state_q)
            IDLE:    if (run) state_d = FETCH;
            FETCH:   if (capture && (bus.imem_instr[INSTR_W-1 -: 3] == HALT_OPC)) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
        endcase

        if (capture) begin
            pc_d = pc_q + ADDR_W'(1);
            if (pc_q == '1) pc_wrapped_d = 1'b1;
        end

        if (transfer && (fetch_count_q != 16'hFFFF)) begin
            fetch_count_d = fetch_count_q + 16'd1;
        end

        if (flush) begin
            state_d      = FETCH;
            pc_d         = redirect_target;
            pc_wrapped_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            pc_wrapped_q  <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pc_wrapped_q  <= pc_wrapped_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    fetch_out_reg #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_out_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .load       (capture),
        .load_instr (bus.imem_instr),
        .load_pc    (pc_q),
        .ready      (bus.out_ready),
        .valid      (out_valid),
        .instr      (out_instr),
        .pc         (out_pc)
    );

    assign bus.imem_addr = pc_q;
    assign bus.out_valid = out_valid;
    assign bus.out_instr = out_instr;
    assign bus.out_pc    = out_pc;
    assign halted        = (state_q == HALTED);
    assign pc_wrapped    = pc_wrapped_q;
    assign fetch_count   = fetch_count_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order delivery scoreboard.
module tb_instr_fetch_unit;

    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] instr;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic       redirect_valid;
    logic [7:0] redirect_target;
    logic       halted;
    logic       pc_wrapped;
    logic [15:0] fetch_count;

    logic [15:0] mem [256];
    exp_t        sb [$];
    int          vectors;
    int          miscompares;

    instr_fetch_unit_if #(.ADDR_W(8), .INSTR_W(16)) bus ();

    instr_fetch_unit #(
        .ADDR_W   (8),
        .INSTR_W  (16),
        .RESET_PC (8'h00),
        .HALT_OPC (3'b111)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .run             (run),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halted          (halted),
        .pc_wrapped      (pc_wrapped),
        .fetch_count     (fetch_count)
    );

    assign bus.imem_instr = mem[bus.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] a);
        sb.push_back({a, mem[a]});
    endtask

    task automatic wait_halt(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (halted && !bus.out_valid) break;
            tick();
        end
        check(tag, {31'd0, (halted && !bus.out_valid)}, 32'd1);
    endtask

    // Scoreboard: every transfer decode will see at the next edge must match the queue head
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready && !redirect_valid) begin
            vectors++;
            assert (sb.size() != 0) else begin
                miscompares++;
                $error("FAIL sb_extra: observed pc %0h with no expected entry", bus.out_pc);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("sb_pc_instr", {8'd0, bus.out_pc, bus.out_instr}, {8'd0, e.pc, e.instr});
            end
        end
    end

    initial begin
        vectors         = 0;
        miscompares     = 0;
        rst_n           = 1'b0;
        run             = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 8'h00;
        bus.out_ready   = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = {8'h0A, 8'(i)};
        mem[7] = 16'hE000;

        // Reset values
        #3;
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_instr", {16'd0, bus.out_instr}, 32'd0);
        check("rst_out_pc", {24'd0, bus.out_pc}, 32'd0);
        check("rst_imem_addr", {24'd0, bus.imem_addr}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_pc_wrapped", {31'd0, pc_wrapped}, 32'd0);
        check("rst_fetch_count", {16'd0, fetch_count}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Straight-line fetch 0..7, halting on mem[7]
        run           = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) push_exp(8'(i));
        tick();
        for (int i = 0; i < 10; i++) begin
            if (bus.out_valid) break;
            tick();
        end
        check("sl_first_valid", {31'd0, bus.out_valid}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            check("sl_out_pc", {24'd0, bus.out_pc}, 32'(i));
            if (i == 7) check("sl_halted_after_capture", {31'd0, halted}, 32'd1);
            tick();
        end
        check("sl_valid_drop", {31'd0, bus.out_valid}, 32'd0);
        check("sl_fetch_count", {16'd0, fetch_count}, 32'd8);
        check("sl_imem_addr", {24'd0, bus.imem_addr}, 32'd8);
        tick(2);
        check("sl_halted_hold", {31'd0, halted}, 32'd1);
        check("sl_imem_addr_hold", {24'd0, bus.imem_addr}, 32'd8);

        // Back-pressure at out_pc=2
        redirect_valid  = 1'b1;
        redirect_target = 8'h00;
        for (int i = 0; i < 8; i++) push_exp(8'(i));
        tick();
        redirect_valid = 1'b0;
        check("bp_halted_clear", {31'd0, halted}, 32'd0);
        check("bp_flush_valid", {31'd0, bus.out_valid}, 32'd0);
        tick(3);
        check("bp_pc2", {24'd0, bus.out_pc}, 32'd2);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_stall_pc", {24'd0, bus.out_pc}, 32'd2);
            check("bp_stall_instr", {16'd0, bus.out_instr}, {16'd0, mem[2]});
            check("bp_stall_addr", {24'd0, bus.imem_addr}, 32'd3);
        end
        bus.out_ready = 1'b1;
        tick();
        check("bp_release_pc", {24'd0, bus.out_pc}, 32'd3);
        wait_halt("bp_halt_reached");
        check("bp_fetch_count", {16'd0, fetch_count}, 32'd16);

        // Redirect to 0x40 while out_pc=4 is offered
        redirect_valid  = 1'b1;
        redirect_target = 8'h00;
        for (int i = 0; i < 4; i++) push_exp(8'(i));
        push_exp(8'h40);
        tick();
        redirect_valid = 1'b0;
        tick(5);
        check("rd_pc4", {24'd0, bus.out_pc}, 32'd4);
        check("rd_count_before", {16'd0, fetch_count}, 32'd20);
        redirect_valid  = 1'b1;
        redirect_target = 8'h40;
        tick();
        redirect_valid = 1'b0;
        check("rd_flush_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rd_not_counted", {16'd0, fetch_count}, 32'd20);
        check("rd_imem_addr", {24'd0, bus.imem_addr}, 32'h40);
        tick();
        check("rd_pc40", {24'd0, bus.out_pc}, 32'h40);
        tick();
        check("rd_pc41", {24'd0, bus.out_pc}, 32'h41);
        check("rd_count_after", {16'd0, fetch_count}, 32'd21);

        // Wrap FE -> FF -> 00 (flushes 0x41)
        redirect_valid  = 1'b1;
        redirect_target = 8'hFE;
        push_exp(8'hFE);
        push_exp(8'hFF);
        for (int i = 0; i < 8; i++) push_exp(8'(i));
        tick();
        redirect_valid = 1'b0;
        check("wr_imem_addr", {24'd0, bus.imem_addr}, 32'hFE);
        tick();
        check("wr_pcFE", {24'd0, bus.out_pc}, 32'hFE);
        check("wr_flag_low", {31'd0, pc_wrapped}, 32'd0);
        tick();
        check("wr_pcFF", {24'd0, bus.out_pc}, 32'hFF);
        check("wr_addr_zero", {24'd0, bus.imem_addr}, 32'h00);
        check("wr_flag_set", {31'd0, pc_wrapped}, 32'd1);
        tick();
        check("wr_pc00", {24'd0, bus.out_pc}, 32'h00);
        wait_halt("wr_halt_reached");
        check("wr_flag_sticky", {31'd0, pc_wrapped}, 32'd1);
        check("wr_fetch_count", {16'd0, fetch_count}, 32'd31);

        // Restart from HALTED at 0x10
        redirect_valid  = 1'b1;
        redirect_target = 8'h10;
        push_exp(8'h10);
        tick();
        redirect_valid = 1'b0;
        check("hr_halted_clear", {31'd0, halted}, 32'd0);
        check("hr_flag_cleared", {31'd0, pc_wrapped}, 32'd0);
        check("hr_imem_addr", {24'd0, bus.imem_addr}, 32'h10);
        tick();
        check("hr_pc10", {24'd0, bus.out_pc}, 32'h10);
        tick();
        check("hr_pc11", {24'd0, bus.out_pc}, 32'h11);
        bus.out_ready = 1'b0;
        tick();
        check("hr_stall_valid", {31'd0, bus.out_valid}, 32'd1);
        check("hr_fetch_count", {16'd0, fetch_count}, 32'd32);

        // Async reset mid-stall, no clock edge in between
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("ar_imem_addr", {24'd0, bus.imem_addr}, 32'd0);
        check("ar_out_pc", {24'd0, bus.out_pc}, 32'd0);
        check("ar_fetch_count", {16'd0, fetch_count}, 32'd0);
        check("ar_halted", {31'd0, halted}, 32'd0);
        run           = 1'b0;
        bus.out_ready = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        check("ar_idle_valid", {31'd0, bus.out_valid}, 32'd0);
        check("ar_idle_addr", {24'd0, bus.imem_addr}, 32'd0);
        check("ar_idle_count", {16'd0, fetch_count}, 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage of the RISC FSM core; sits directly upstream of the 256x16 instruction memory and downstream-feeds the decoder.
- Owns the program counter and drives the memory address.
- Captures the returned 16-bit instruction into an output register and presents it to decode with a valid/ready handshake.
- Handles PC redirect (branch/jump), halt-opcode detection and stall back-pressure.

Parameters:
- ADDR_W, 8, PC / memory address width (256 locations)
- INSTR_W, 16, instruction width
- RESET_PC, 8'h00, PC value loaded on reset
- HALT_OPC, 3'b111, opcode in instr[15:13] that stops fetching

Ports:
- clk  input  1  core clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- imem_addr  output  ADDR_W  address to instruction memory; equals the pc register
- imem_instr  input  INSTR_W  instruction memory read data; combinational, valid in the same cycle as imem_addr
- run  input  1  level; 1 permits fetching from IDLE
- redirect_valid  input  1  one-cycle pulse: load new PC and flush
- redirect_target  input  ADDR_W  new PC, sampled when redirect_valid=1
- out_valid  output  1  instruction register holds a valid instruction
- out_ready  input  1  decoder accepts the instruction this cycle
- out_instr  output  INSTR_W  fetched instruction
- out_pc  output  ADDR_W  address the instruction was fetched from
- halted  output  1  1 while in HALTED state
- pc_wrapped  output  1  sticky; set when PC increments 255->0, cleared by reset or redirect
- fetch_count  output  16  number of instructions accepted by decode; saturates at 16'hFFFF

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=IDLE.
  - out_valid=0, out_instr=0, out_pc=0.
  - halted=0, pc_wrapped=0, fetch_count=0.
- States:
  - IDLE -> FETCH when run=1.
  - FETCH -> HALTED when the instruction being captured has instr[15:13]==HALT_OPC.
  - HALTED -> FETCH only on redirect_valid. run is ignored once out of IDLE.
- Capture condition: state==FETCH and (out_valid==0 or out_ready==1). When it holds:
  - out_instr<=imem_instr, out_pc<=pc, out_valid<=1.
  - pc<=pc+1, modulo 2^ADDR_W.
  - If pc was 8'hFF, set pc_wrapped.
- Throughput: one instruction per cycle when out_ready is held high.
- Latency: an instruction appears on out_* one cycle after its address is driven.
- Stall: out_valid=1 and out_ready=0 -> out_instr, out_pc and pc hold. No fetch occurs.
- Handshake:
  - Transfer happens when out_valid and out_ready are both high.
  - If there is no new capture in the same cycle, out_valid<=0.
  - fetch_count increments by 1 on each transfer (saturating).
- Halt:
  - The HALT instruction is itself delivered to decode.
  - In HALTED, after the final transfer out_valid falls to 0 and pc holds at HALT address+1.
  - halted=1 from the cycle after capture.
- Redirect (highest priority, any state except IDLE):
  - pc<=redirect_target, out_valid<=0, pc_wrapped<=0, state<=FETCH.
  - The instruction currently in the output register is discarded and is not counted.
  - The first capture at redirect_target happens the cycle after the redirect.
- Redirect in IDLE is ignored.
- Redirect and out_ready in the same cycle: flush wins, no transfer counted.
- Reset mid-operation: immediate return to reset values. No partial transfer.
- imem_addr is combinational from pc. No other output depends combinationally on inputs.

Decomposition:
- Shared package core_pkg holds:
  - ADDR_W, INSTR_W
  - opcode constants: OPC_ADD=000, OPC_SUB=001, OPC_AND=010, OPC_OR=011, OPC_NOT=100, OPC_LDI=101, OPC_HALT=111
  - fetch state enum {IDLE, FETCH, HALTED}
- One natural sub-module: fetch_out_reg, the output register with valid/ready and flush.
- The FSM, PC and counter remain in instr_fetch_unit.

Test Plan:
- Straight-line fetch: reset, run=1, out_ready=1; memory 0..6 = program, mem[7]=16'hE000 -> out_pc 0,1,...,7 on consecutive cycles; halted=1 after pc 7; fetch_count=8; imem_addr holds 8.
- Back-pressure: out_ready=0 for 3 cycles while out_pc=2 -> out_instr=mem[2] stable and imem_addr=3 held; release -> pc 3 delivered next cycle; no instruction lost or duplicated.
- Redirect: redirect_valid with target 8'h40 while out_pc=4 is valid and out_ready=1 -> pc 4 not counted; next out_pc=8'h40, then 8'h41.
- Wrap: redirect to 8'hFE, NOP memory -> out_pc FE, FF, 00, 01; pc_wrapped rises on the cycle pc goes 00; a later redirect clears it.
- Halt restart: in HALTED, redirect_valid target 8'h10 -> halted=0 next cycle; fetch resumes at 8'h10.
- Async reset mid-stall: rst_n low while out_valid=1 -> out_valid=0 and pc=RESET_PC immediately without a clock edge; run=0 after reset keeps IDLE with out_valid=0.
